counter_arbiter: RTL
====================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters sharing the counter.
REQ-002 SHALL have parameter WIDTH, default 4, counter width; MAX = 2**WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req  input  N  per-requester operation request, held high until ack or err.
REQ-006 SHALL have port dir  input  N  per-requester direction; 0 = increment, 1 = decrement.
REQ-007 SHALL have port ack  output  N  one-cycle pulse: granted operation applied.
REQ-008 SHALL have port err  output  N  one-cycle pulse: granted operation rejected (saturation).
REQ-009 SHALL have port count  output  WIDTH  registered counter value.
REQ-010 SHALL have port full  output  1  high when count == MAX, derived from the count register.
REQ-011 SHALL have port empty  output  1  high when count == 0, derived from the count register.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, WAIT; reset state IDLE.
REQ-013 IDLE: if any req bit is high, SHALL select one index by round-robin from pointer ptr, register idx and dir[idx], go EXEC; else stay IDLE.
REQ-014 Round-robin SHALL pick the first set req bit at or above ptr, wrapping from N-1 to 0.
REQ-015 EXEC: SHALL apply the operation to count, set ack[idx] or err[idx] for the next cycle, set ptr = (idx+1) mod N, go WAIT.
REQ-016 Increment with count == MAX, or decrement with count == 0, SHALL leave count unchanged and pulse err[idx] instead of ack[idx].
REQ-017 Otherwise count SHALL become count+1 or count-1 (WIDTH bits), never wrapping.
REQ-018 WAIT: SHALL drive exactly one ack or err bit high for this single cycle, ignore req, return to IDLE.
REQ-019 Latency: req sampled in IDLE at cycle T -> new count and ack/err visible in cycle T+2; next grant sampled no earlier than T+3.
REQ-020 Requester SHALL drop req in the cycle it sees ack/err; a req still high in IDLE at T+3 is treated as a new request.
REQ-021 dir SHALL be sampled only at grant in IDLE; dir changes during EXEC/WAIT have no effect.
REQ-022 Once granted, a deassertion of req during EXEC SHALL NOT cancel the operation.
REQ-023 At most one bit of ack|err SHALL be high in any cycle; both SHALL be zero outside WAIT.
REQ-024 Simultaneous requests SHALL be served one per arbitration round in round-robin order, never starving any requester.

Reset
REQ-025 Reset high SHALL asynchronously force state IDLE, count 0, ptr 0, idx 0, ack 0, err 0 (thus empty 1, full 0).
REQ-026 Reset asserted mid-operation (EXEC/WAIT) SHALL discard the operation; no ack/err pulse after reset release.
REQ-027 First grant after reset release SHALL occur no earlier than the first rising edge with reset low.

Structure
REQ-028 Shared package counter_pkg SHALL hold the FSM state encoding (IDLE, EXEC, WAIT) and the default N and WIDTH constants.
REQ-029 Round-robin selection SHALL be one combinational sub-module counter_rr_pick (inputs req, ptr; outputs idx, valid).
REQ-030 count, ptr, idx, sampled dir, ack, err SHALL be registers in counter_arbiter; full/empty combinational from count.

Verification
REQ-031 Reset, req[0]=1 dir[0]=0 held -> ack[0] pulses at T+2, count=1, empty=0.
REQ-032 From count=0, req[2]=1 dir[2]=1 -> err[2] pulse at T+2, count stays 0, ack stays 0.
REQ-033 Drive 15 increments from requester 1 then one more (WIDTH=4) -> count=15, full=1, 16th gives err[1], count stays 15.
REQ-034 req=4'b1111 held, all dir=0, ptr=0 -> ack order 0,1,2,3,0, each 3 cycles apart, count increments by 1 each.
REQ-035 Grant requester 3 at count=5 dir=0, assert reset during EXEC -> count=0, no ack[3], state IDLE, next grant from ptr=0.
REQ-036 Grant requester 0 with dir=0, flip dir[0] to 1 and drop req[0] during EXEC -> ack[0] still pulses, count incremented.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared FSM encoding and default sizing for the counter arbiter
package counter_pkg;

  // Arbitration round: pick a requester, apply its operation, show the pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/counter_rr_pick.sv
// rtl/counter_rr_pick.sv - combinational round-robin selector over the request vector
module counter_rr_pick
  import counter_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic          hi_found;
  logic [PW-1:0] hi_idx;
  logic          lo_found;
  logic [PW-1:0] lo_idx;

  // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
        if (PW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    valid = lo_found;
    idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - saturating up/down counter shared by N round-robin requesters
module counter_arbiter
  import counter_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     dir,
  output logic [N-1:0]     ack,
  output logic [N-1:0]     err,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int             PW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MAXV = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    ptr_q,   ptr_d;
  logic [PW-1:0]    idx_q,   idx_d;
  logic             dir_q,   dir_d;
  logic [N-1:0]     ack_q,   ack_d;
  logic [N-1:0]     err_q,   err_d;

  logic [PW-1:0]    pick_idx;
  logic             pick_valid;

  counter_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next-state: grant in IDLE, apply in EXEC, pulse in WAIT; dir is captured only at grant
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          dir_d   = dir[pick_idx];
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (dir_q) begin
          if (count_q == '0) begin
            err_d[idx_q] = 1'b1;
          end else begin
            count_d      = count_q - 1'b1;
            ack_d[idx_q] = 1'b1;
          end
        end else begin
          if (count_q == MAXV) begin
            err_d[idx_q] = 1'b1;
          end else begin
            count_d      = count_q + 1'b1;
            ack_d[idx_q] = 1'b1;
          end
        end
        if (idx_q == PW'(N - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = idx_q + 1'b1;
        end
        state_d = WAIT;
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign count = count_q;
  assign full  = (count_q == MAXV);
  assign empty = (count_q == '0);

endmodule
